// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if -- request/response bundle between the pipeline and the
// HI/LO multiply unit.
//   master : pipeline side (drives start/aluop/operands/mthi-mtlo strobes)
//   slave  : multiply unit side (drives busy/done/result/hi/lo)
//   start          one-cycle multiply request
//   aluop[4:0]     operation code (31 mult, 26 multu, 30 madd, 29 msub,
//                  28 mfhi, 27 mflo)
//   a, b [31:0]    source operands (rs, rt)
//   writehi/lo     mthi/mtlo strobes, load a into HI/LO
//   busy           stall request while the multiply iterates
//   done           one-cycle completion pulse
//   result[31:0]   read port (HI for mfhi, LO otherwise)
//   hi, lo [31:0]  architectural HI/LO registers
interface hilo_mult_unit_if;
  logic        start;
  logic [4:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        writehi;
  logic        writelo;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, aluop, a, b, writehi, writelo,
    input  busy, done, result, hi, lo
  );

  modport slave (
    input  start, aluop, a, b, writehi, writelo,
    output busy, done, result, hi, lo
  );
endinterface

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit -- iterative radix-2 shift-add multiplier owning the MIPS
// HI/LO register pair (mult, multu, madd, msub, mfhi, mflo, mthi, mtlo).
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hilo_mult_unit_if.slave (see interface file for signal list)
// A multiply is accepted only in IDLE, iterates one multiplier bit per cycle
// in RUN, and commits {HI,LO} on the RUN->DONE edge. Signed ops multiply the
// magnitudes and negate the 64-bit product at the end.
// Build option: define HILO_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module hilo_mult_unit (
  input  logic                  clk,
  input  logic                  rst,
  hilo_mult_unit_if.slave       bus
);
  localparam int DATA_W = 32;

  localparam logic [4:0] OP_MULT  = 5'd31;
  localparam logic [4:0] OP_MULTU = 5'd26;
  localparam logic [4:0] OP_MADD  = 5'd30;
  localparam logic [4:0] OP_MSUB  = 5'd29;
  localparam logic [4:0] OP_MFHI  = 5'd28;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [2*DATA_W-1:0]     acc;
  logic [2*DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]       mplier;
  logic [5:0]              cnt;
  logic                    neg;
  logic [4:0]              op;
  logic [DATA_W-1:0]       hi_r;
  logic [DATA_W-1:0]       lo_r;
  logic                    busy_r;
  logic                    done_r;

  logic                    start_mul;
  logic                    signed_op;
  logic [2*DATA_W-1:0]     acc_step;
  logic [2*DATA_W-1:0]     prod;
  logic [2*DATA_W-1:0]     hilo_new;
  logic                    last_iter;

  // Magnitude as an unsigned 32-bit value; 0x80000000 maps to itself.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] nv;
    nv = -v;
    return v[DATA_W-1] ? DATA_W'(nv) : DATA_W'(v);
  endfunction

  always_comb begin
    start_mul = bus.start && (bus.aluop == OP_MULT || bus.aluop == OP_MULTU ||
                              bus.aluop == OP_MADD || bus.aluop == OP_MSUB);
    signed_op = (bus.aluop != OP_MULTU);
    acc_step  = mplier[0] ? acc + mcand : acc;
    prod      = neg ? (~acc_step + 64'd1) : acc_step;
`ifdef HILO_EARLY_TERM_EN
    last_iter = (cnt == 6'd31) || (mplier[DATA_W-1:1] == '0);
`else
    last_iter = (cnt == 6'd31);
`endif
    case (op)
      OP_MADD: hilo_new = {hi_r, lo_r} + prod;
      OP_MSUB: hilo_new = {hi_r, lo_r} - prod;
      default: hilo_new = prod;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      op     <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (start_mul) begin
            // A valid multiply start drops any simultaneous mthi/mtlo.
            state  <= RUN;
            busy_r <= 1'b1;
            acc    <= '0;
            cnt    <= '0;
            op     <= bus.aluop;
            if (signed_op) begin
              mcand  <= {{DATA_W{1'b0}}, mag(bus.a)};
              mplier <= mag(bus.b);
              neg    <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
            end else begin
              mcand  <= {{DATA_W{1'b0}}, bus.a};
              mplier <= bus.b;
              neg    <= 1'b0;
            end
          end else begin
            if (bus.writehi) hi_r <= bus.a;
            if (bus.writelo) lo_r <= bus.a;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (last_iter) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            {hi_r, lo_r} <= hilo_new;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
  assign bus.result = (bus.aluop == OP_MFHI) ? hi_r : lo_r;
endmodule

// File: tb/tb_hilo_mult_unit.sv
module tb_hilo_mult_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   saw_done;

  hilo_mult_unit_if bus ();

  hilo_mult_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one rising edge; returns half a cycle after that edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.aluop = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done; lat = cycles from start edge through the DONE cycle.
  task automatic wait_done(output int l);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'd0, bus.done}, 64'd1);
    l = n + 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.aluop = 5'd0;
    bus.a = '0;
    bus.b = '0;
    bus.writehi = 1'b0;
    bus.writelo = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;

    // mult 7 * -3
    issue(5'd31, 32'd7, 32'hFFFF_FFFD);
    chk("mult_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(lat);
`ifndef HILO_EARLY_TERM_EN
    chk("mult_latency", 64'(lat), 64'd33);
`endif
    chk("mult_busy_done", {63'd0, bus.busy}, 64'd0);
    chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);

    // multu all-ones, with a mtlo attempt during RUN
    issue(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.writelo = 1'b1;
    bus.a = 32'h0000_DEAD;
    @(negedge clk);
    bus.writelo = 1'b0;
    chk("mtlo_in_run", 64'(bus.lo), 64'hFFFF_FFEB);
    wait_done(lat);
    chk("multu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // madd / msub chain from a clean HI/LO
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.writelo = 1'b1;
    bus.a = 32'd10;
    @(negedge clk);
    bus.writelo = 1'b0;
    chk("mtlo_hilo", {bus.hi, bus.lo}, 64'd10);
    issue(5'd30, 32'd2, 32'd3);
    wait_done(lat);
    chk("madd_hilo", {bus.hi, bus.lo}, 64'd16);
    issue(5'd29, 32'd4, 32'd5);
    wait_done(lat);
    chk("msub_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFC);

    // most-negative squared, second start in RUN ignored, mfhi during DONE
    issue(5'd31, 32'h8000_0000, 32'h8000_0000);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(lat);
    chk("minint_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    bus.aluop = 5'd28;
    #1;
    chk("mfhi_in_done", 64'(bus.result), 64'h4000_0000);
    bus.aluop = 5'd27;
    #1;
    chk("mflo_in_done", 64'(bus.result), 64'd0);

    // reset aborts a multiply in RUN
    issue(5'd26, 32'd5, 32'd6);
`ifdef HILO_EARLY_TERM_EN
    @(negedge clk);
`else
    repeat (9) @(negedge clk);
`endif
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    bus.writehi = 1'b1;
    bus.a = 32'h0000_1234;
    @(negedge clk);
    bus.writehi = 1'b0;
    chk("mthi_after_abort", {bus.hi, bus.lo}, 64'h0000_1234_0000_0000);

    // both strobes together
    bus.writehi = 1'b1;
    bus.writelo = 1'b1;
    bus.a = 32'hCAFE_F00D;
    @(negedge clk);
    bus.writehi = 1'b0;
    bus.writelo = 1'b0;
    chk("mthi_mtlo", {bus.hi, bus.lo}, 64'hCAFE_F00D_CAFE_F00D);

    // start with a non-multiply op is ignored
    issue(5'd28, 32'd3, 32'd4);
    chk("bad_op_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk("bad_op_done", {63'd0, bus.done}, 64'd0);

    // start wins over a simultaneous mthi
    @(negedge clk);
    bus.start = 1'b1;
    bus.aluop = 5'd26;
    bus.a = 32'd3;
    bus.b = 32'd4;
    bus.writehi = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.writehi = 1'b0;
    chk("start_wins_busy", {63'd0, bus.busy}, 64'd1);
    chk("start_wins_hi", 64'(bus.hi), 64'hCAFE_F00D);
    wait_done(lat);
    chk("start_wins_hilo", {bus.hi, bus.lo}, 64'd12);

    // multu 9 * 1 latency
    @(negedge clk);
    issue(5'd26, 32'd9, 32'd1);
    wait_done(lat);
`ifdef HILO_EARLY_TERM_EN
    chk("short_latency", 64'(lat), 64'd2);
`else
    chk("short_latency", 64'(lat), 64'd33);
`endif
    chk("short_hilo", {bus.hi, bus.lo}, 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
